// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash read sequencer.
// Build option: SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B) with a DUMMY phase.
package spi_flash_pkg;

   localparam logic [7:0] SPI_OP_READ      = 8'h03;
   localparam logic [7:0] SPI_OP_FAST_READ = 8'h0B;
   localparam int         CMD_BITS         = 32;
   localparam int         DUMMY_BITS       = 8;

`ifdef SPI_FLASH_FAST_READ_EN
   localparam bit FAST_READ = 1'b1;
   typedef enum logic [2:0] {IDLE, CMD, DUMMY, DATA, GAP} state_e;
`else
   localparam bit FAST_READ = 1'b0;
   typedef enum logic [1:0] {IDLE, CMD, DATA, GAP} state_e;
`endif

   localparam logic [7:0] SPI_OPCODE = FAST_READ ? SPI_OP_FAST_READ : SPI_OP_READ;

endpackage

// File: rtl/spi_flash_sck_gen.sv
// SCK divider: toggles sck every CLK_DIV aclk cycles while enabled, freezes on stall,
// and flags the aclk edge that will raise (rise) or lower (fall) sck.
module spi_flash_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic stall,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          tc;

   assign tc   = en && !stall && (cnt == CW'(CLK_DIV - 1));
   assign rise = tc && !sck;
   assign fall = tc && sck;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         sck <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         sck <= 1'b0;
      end else if (!stall) begin
         if (tc) begin
            cnt <= '0;
            sck <= ~sck;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_flash_rd_seq.sv
// SPI flash READ sequencer (mode 0, MSB first): opcode+address frame, DW-bit words out
// on a valid/ready stream with sck stretching on back-pressure. Option: SPI_FLASH_FAST_READ_EN.
module spi_flash_rd_seq
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int DW      = 32,
   parameter int CS_GAP  = 4
) (
   input  logic          spi_flash_aclk,
   input  logic          spi_flash_areset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_cs,
   input  logic [23:0]   req_addr,
   input  logic [7:0]    req_len,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_last,
   output logic [3:0]    spi_csn_o,
   output logic          spi_sck,
   output logic          spi_sdo_o,
   output logic          spi_sdo_en,
   input  logic          spi_sdi_i,
   output logic          busy
);

   localparam int BIT_W = $clog2((DW > CMD_BITS) ? DW : CMD_BITS);
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   state_e              state, state_nxt;
   logic [1:0]          cs_q;
   logic [7:0]          len_q, word_cnt;
   logic [CMD_BITS-1:0] shift_out;
   logic [DW-1:0]       shift_in;
   logic [BIT_W-1:0]    bit_cnt, bit_lim;
   logic [GAP_W-1:0]    gap_cnt;
   logic                pending, active, rise, fall, last_bit;
   logic                handshake, word_done, out_free, load;

   spi_flash_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
      .clk   (spi_flash_aclk),
      .rst   (spi_flash_areset),
      .en    (active),
      .stall (pending),
      .sck   (spi_sck),
      .rise  (rise),
      .fall  (fall)
   );

   // Reset is folded in so the front end never sees a ready while the block is held.
   assign req_ready  = (state == IDLE) && !spi_flash_areset;
   assign handshake  = req_valid && req_ready;
   assign active     = (state != IDLE) && (state != GAP);
   assign last_bit   = (bit_cnt == bit_lim);
   assign word_done  = (state == DATA) && fall && last_bit;
   assign out_free   = !rsp_valid || rsp_ready;
   assign load       = (word_done || pending) && out_free;

   assign spi_csn_o  = active ? ~(4'b0001 << cs_q) : 4'hF;
   assign spi_sdo_en = (state == CMD);
   assign spi_sdo_o  = (state == CMD) && shift_out[CMD_BITS-1];
   assign busy       = (state != IDLE) || rsp_valid;

   always_comb begin
      // NOTE: default first so no path through the case leaves bit_lim unassigned (latch).
      bit_lim = BIT_W'(CMD_BITS - 1);
      case (state)
`ifdef SPI_FLASH_FAST_READ_EN
         DUMMY:   bit_lim = BIT_W'(DUMMY_BITS - 1);
`endif
         DATA:    bit_lim = BIT_W'(DW - 1);
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = CMD;
`ifdef SPI_FLASH_FAST_READ_EN
         CMD:   if (fall && last_bit) state_nxt = DUMMY;
         DUMMY: if (fall && last_bit) state_nxt = DATA;
`else
         CMD:   if (fall && last_bit) state_nxt = DATA;
`endif
         DATA: if (load && (word_cnt == len_q)) state_nxt = GAP;
         GAP:  if (gap_cnt == GAP_W'(CS_GAP - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge spi_flash_aclk or posedge spi_flash_areset) begin
      if (spi_flash_areset) state <= IDLE;
      else                  state <= state_nxt;
   end

   always_ff @(posedge spi_flash_aclk or posedge spi_flash_areset) begin
      if (spi_flash_areset) begin
         cs_q      <= '0;
         len_q     <= '0;
         word_cnt  <= '0;
         shift_out <= '0;
         shift_in  <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         pending   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_data  <= '0;
      end else begin
         if (handshake) begin
            cs_q      <= req_cs;
            len_q     <= req_len;
            word_cnt  <= '0;
            shift_out <= {SPI_OPCODE, req_addr};
            bit_cnt   <= '0;
         end
         // Bits complete on the falling edge; sdo only moves while sck is low.
         if (fall) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            if (state == CMD) shift_out <= {shift_out[CMD_BITS-2:0], 1'b0};
         end
         if (rise && (state == DATA)) shift_in <= {shift_in[DW-2:0], spi_sdi_i};
         // A finished word that cannot be handed off holds sck low until the slot frees.
         pending <= (word_done || pending) && !out_free;
         if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= shift_in;
            rsp_last  <= (word_cnt == len_q);
            word_cnt  <= word_cnt + 1'b1;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      end
   end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Self-checking bench: a behavioural SPI flash (byte array) plus a response scoreboard.
`timescale 1ns/1ps
module tb_spi_flash_rd_seq;

   localparam int CLK_DIV = 2;
   localparam int DW      = 32;
   localparam int CS_GAP  = 4;
`ifdef SPI_FLASH_FAST_READ_EN
   localparam int         HDR = 40;
   localparam logic [7:0] OPC = 8'h0B;
`else
   localparam int         HDR = 32;
   localparam logic [7:0] OPC = 8'h03;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_cs = '0;
   logic [23:0]   req_addr = '0;
   logic [7:0]    req_len = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic          rsp_last;
   logic [3:0]    csn;
   logic          sck, sdo, sdo_en;
   logic          sdi = 1'b0;
   logic          busy;

   always #5 clk = ~clk;

   spi_flash_rd_seq #(.CLK_DIV(CLK_DIV), .DW(DW), .CS_GAP(CS_GAP)) dut (
      .spi_flash_aclk   (clk),
      .spi_flash_areset (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_cs           (req_cs),
      .req_addr         (req_addr),
      .req_len          (req_len),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_data         (rsp_data),
      .rsp_last         (rsp_last),
      .spi_csn_o        (csn),
      .spi_sck          (sck),
      .spi_sdo_o        (sdo),
      .spi_sdo_en       (sdo_en),
      .spi_sdi_i        (sdi),
      .busy             (busy)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Flash contents; addresses wrap on 1 KiB.
   logic [7:0] mem [1024];

   function automatic logic [DW-1:0] flash_word(input int a);
      logic [DW-1:0] w;
      w = '0;
      for (int i = 0; i < DW / 8; i++) w = (w << 8) | DW'(mem[(a + i) % 1024]);
      return w;
   endfunction

   logic [DW:0]   exp_q [$];
   logic [1:0]    exp_cs = '0;
   logic [23:0]   exp_addr = '0;
   logic [7:0]    exp_len = '0;
   bit            exp_stall = 1'b0;
   int            rdy_mode = 0;

   // Flash slave + pin monitor + response scoreboard, all sampled mid-cycle.
   int            bit_n = 0, low_cycles = 0, csn_err = 0, en_err = 0, idle_err = 0;
   int            gap_n = 0, stab_err = 0, di = 0;
   logic [31:0]   cmd = '0;
   logic [7:0]    fb = '0;
   logic          prev_sck = 1'b0, was_low = 1'b0, in_gap = 1'b0, held = 1'b0, held_last = 1'b0;
   logic [DW-1:0] held_data = '0;
   logic [DW:0]   e = '0;

   always @(negedge clk) begin
      if (rst) begin
         bit_n = 0; low_cycles = 0; csn_err = 0; en_err = 0;
         prev_sck = 1'b0; was_low = 1'b0; in_gap = 1'b0; held = 1'b0; sdi = 1'b0;
      end else begin
         if (csn != 4'hF) begin
            low_cycles++;
            if (csn !== ~(4'b0001 << exp_cs)) csn_err++;
            if (sck && !prev_sck) begin
               if (bit_n < 32) begin
                  cmd = {cmd[30:0], sdo};
                  if (sdo_en !== 1'b1) en_err++;
               end else if (sdo_en !== 1'b0 || sdo !== 1'b0) begin
                  en_err++;
               end
               bit_n++;
            end
            if (bit_n >= HDR) begin
               di  = bit_n - HDR;
               fb  = mem[(int'(cmd[23:0]) + di / 8) % 1024];
               sdi = fb[7 - (di % 8)];
            end else begin
               sdi = 1'b0;
            end
            was_low = 1'b1;
         end else begin
            if (sck !== 1'b0 || sdo_en !== 1'b0) idle_err++;
            if (was_low) begin
               check("opcode", cmd[31:24], OPC);
               check("addr", cmd[23:0], exp_addr);
               check("csn_sel", csn_err, 0);
               check("sdo_en", en_err, 0);
               check("sck_bits", bit_n, HDR + DW * (int'(exp_len) + 1));
               if (!exp_stall)
                  check("frame_len", low_cycles, 2 * CLK_DIV * (HDR + DW * (int'(exp_len) + 1)));
               bit_n = 0; low_cycles = 0; csn_err = 0; en_err = 0;
               was_low = 1'b0; in_gap = 1'b1; gap_n = 0; sdi = 1'b0;
            end
            if (in_gap) begin
               if (req_ready) begin
                  check("gap_len", gap_n, CS_GAP);
                  in_gap = 1'b0;
               end else begin
                  gap_n++;
               end
            end
         end
         prev_sck = sck;

         if (rsp_valid) begin
            if (held && (rsp_data !== held_data || rsp_last !== held_last)) stab_err++;
            if (rsp_ready) begin
               check("rsp_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("rsp_data", rsp_data, e[DW-1:0]);
                  check("rsp_last", rsp_last, e[DW]);
               end
               held = 1'b0;
            end else begin
               held = 1'b1; held_data = rsp_data; held_last = rsp_last;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   // rsp_ready: 0 = always ready, 1 = random, 2 = withheld.
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         1:       rsp_ready = 1'($urandom_range(0, 1));
         2:       rsp_ready = 1'b0;
         default: rsp_ready = 1'b1;
      endcase
   end

   task automatic do_req(input logic [1:0] cs, input logic [23:0] addr, input logic [7:0] len,
                         input bit stall);
      int n;
      for (int k = 0; k <= int'(len); k++)
         exp_q.push_back({k == int'(len), flash_word(int'(addr) + k * (DW / 8))});
      exp_cs = cs; exp_addr = addr; exp_len = len; exp_stall = stall;
      @(negedge clk);
      req_valid = 1'b1; req_cs = cs; req_addr = addr; req_len = len;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("req_accept_timeout", n < 100, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_addr = 24'($urandom); req_len = 8'($urandom);
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((busy || !req_ready || exp_q.size() != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", n < limit, 1);
   endtask

   int n, hi, bits0, stab0;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_last", rsp_last, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_csn", csn, 4'hF);
      check("rst_sck", sck, 0);
      check("rst_sdo", {sdo, sdo_en}, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_req_ready", req_ready, 1);

      // Single word with known data.
      mem[12'h056] = 8'hDE; mem[12'h057] = 8'hAD; mem[12'h058] = 8'hBE; mem[12'h059] = 8'hEF;
      check("model_word", flash_word(24'h123456), 32'hDEADBEEF);
      do_req(2'd1, 24'h123456, 8'd0, 1'b0);
      wait_idle(2000);

      // Four back-to-back words, always ready: no stretch allowed.
      do_req(2'd2, 24'($urandom), 8'd3, 1'b0);
      wait_idle(3000);

      // Back-pressure long enough to force a clock stretch on word 1.
      rdy_mode = 2;
      do_req(2'd0, 24'($urandom), 8'd1, 1'b1);
      n = 0;
      while (!rsp_valid && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("first_rsp_timeout", n < 1000, 1);
      stab0 = stab_err; hi = 0; bits0 = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (c == 140) bits0 = bit_n;
         if (c >= 140 && sck) hi++;
      end
      check("stall_sck_low", hi, 0);
      check("stall_no_bits", bit_n, bits0);
      check("stall_rsp_held", rsp_valid, 1);
      check("stall_data_stable", stab_err - stab0, 0);
      rdy_mode = 0;
      wait_idle(2000);

      // Asynchronous reset in the middle of the address phase.
      do_req(2'd3, 24'($urandom), 8'd2, 1'b0);
      n = 0;
      while (bit_n < 28 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("addr_bit20_timeout", n < 1000, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_csn", csn, 4'hF);
      check("mid_rst_sck", sck, 0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_busy", busy, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
      do_req(2'd0, 24'h000010, 8'd0, 1'b0);
      wait_idle(2000);

      // Maximum length: 256 words, counter must not wrap early.
      do_req(2'd1, 24'($urandom), 8'd255, 1'b0);
      wait_idle(40000);

      // Random requests with random back-pressure.
      rdy_mode = 1;
      for (int r = 0; r < 6; r++) begin
         do_req(2'($urandom), 24'($urandom), 8'($urandom_range(0, 5)), 1'b1);
         wait_idle(8000);
      end
      rdy_mode = 0;

      check("scoreboard_empty", exp_q.size(), 0);
      check("data_stable", stab_err, 0);
      check("idle_pins", idle_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
